// File: rtl/divider_ctrl_pkg.sv
// Shared types and helpers for the clock-divider controller.
package divider_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PEND  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Smallest ratio that still produces a real period (one high, one low cycle).
  localparam int unsigned DIV_MIN = 2;

  function automatic logic div_is_legal(input int unsigned n);
    return (n >= DIV_MIN);
  endfunction

endpackage

// File: rtl/div_period_cnt.sv
// Period counter: owns cnt, the divided wave and the end-of-period tick.
// cur_div is the ratio that applies to the *next* cycle, so the registered
// outputs always describe the same cycle that cnt_q does.
module div_period_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [CNT_W-1:0] cur_div,
  input  logic             run,
  input  logic             restart,
  output logic             div_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_out_q, div_out_d;
  logic             tick_q, tick_d;

  // Next count and the wave/tick values that belong to that count.
  // tick_q marks the last cycle of the current period, so it doubles as the wrap condition.
  always_comb begin
    cnt_d = '0;
    if (run && !restart && !tick_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    div_out_d = run && (cnt_d < (cur_div >> 1));
    tick_d    = run && (cnt_d == (cur_div - CNT_W'(1)));
  end

  // Counter and output registers; reset drops the outputs immediately.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      div_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_out_q <= div_out_d;
      tick_q    <= tick_d;
    end
  end

  assign div_out = div_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/divider_ctrl.sv
// Clock-divider controller: run/stop sequencing, ratio handshake and the
// pending-ratio register. Ratio changes and stops land on period boundaries.
module divider_ctrl
  import divider_ctrl_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_out,
  output logic             tick,
  output logic [CNT_W-1:0] cur_div,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             err_q, err_d;

  logic xfer;
  logic take;
  logic run;
  logic restart;

  assign cfg_ready = !pend_vld_q;
  assign xfer      = cfg_valid && cfg_ready;
  assign take      = xfer && div_is_legal(32'(cfg_div));

  // Next-state logic. "tick" is the registered last-cycle-of-period flag,
  // i.e. the only cycle on which a boundary action may happen.
  always_comb begin
    state_d    = state_q;
    cur_div_d  = cur_div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    err_d      = xfer && !div_is_legal(32'(cfg_div));

    unique case (state_q)
      IDLE: begin
        if (take) cur_div_d = cfg_div;
        if (enable) state_d = RUN;
      end

      RUN: begin
        if (take) begin
          if (tick) begin
            cur_div_d = cfg_div;
          end else begin
            pend_d     = cfg_div;
            pend_vld_d = 1'b1;
            state_d    = PEND;
          end
        end
        // A stop on the tick cycle needs no drain: the period is already complete.
        if (!enable) state_d = tick ? IDLE : DRAIN;
      end

      PEND: begin
        if (tick) begin
          cur_div_d  = pend_q;
          pend_vld_d = 1'b0;
          state_d    = enable ? RUN : IDLE;
        end else if (!enable) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        // A ratio can still arrive while draining if none is pending.
        if (take) begin
          if (tick) begin
            cur_div_d = cfg_div;
          end else begin
            pend_d     = cfg_div;
            pend_vld_d = 1'b1;
          end
        end
        if (tick) begin
          if (pend_vld_q) begin
            cur_div_d  = pend_q;
            pend_vld_d = 1'b0;
          end
          state_d = IDLE;
        end
      end
    endcase
  end

  // Control and configuration registers; reset discards any pending ratio.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cur_div_q  <= CNT_W'(DEFAULT_DIV);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_div_q  <= cur_div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      err_q      <= err_d;
    end
  end

  // The counter is told about the next cycle: whether it runs, whether it
  // starts fresh from IDLE, and which ratio that cycle belongs to.
  assign run     = (state_d != IDLE);
  assign restart = (state_q == IDLE);

  div_period_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_in  (clk_in),
    .reset   (reset),
    .cur_div (cur_div_d),
    .run     (run),
    .restart (restart),
    .div_out (div_out),
    .tick    (tick)
  );

  assign cfg_err = err_q;
  assign cur_div = cur_div_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_divider_ctrl.sv
// Bench for divider_ctrl: period-level behavioural model, per-cycle compare,
// directed scenarios with literal expectations, then a randomized phase.
module tb_divider_ctrl;

  localparam int CNT_W = 8;
  localparam int DEF   = 16;

  logic             clk_in    = 1'b0;
  logic             reset     = 1'b0;
  logic             enable    = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_div   = '0;
  logic             cfg_ready;
  logic             cfg_err;
  logic             div_out;
  logic             tick;
  logic [CNT_W-1:0] cur_div;
  logic             busy;

  int vectors     = 0;
  int miscompares = 0;

  divider_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .div_out   (div_out),
    .tick      (tick),
    .cur_div   (cur_div),
    .busy      (busy)
  );

  always #5 clk_in = ~clk_in;

  // Model: a divider is either active or not; when active it sits at some
  // position cnt within a period of length n. A stop request is remembered
  // until the period ends. At most one ratio waits for the next boundary.
  typedef struct {
    int act;
    int stop;
    int cnt;
    int n;
    int pend;
    int err;
  } mstate_t;

  function automatic mstate_t model_reset();
    mstate_t r;
    r.act = 0; r.stop = 0; r.cnt = 0; r.n = DEF; r.pend = -1; r.err = 0;
    return r;
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input logic en,
                                         input logic vld, input int d);
    mstate_t r;
    logic bnd, xf;
    r   = s;
    bnd = (s.act != 0) && (s.cnt == s.n - 1);
    xf  = vld && (s.pend < 0);
    r.err = (xf && d < 2) ? 1 : 0;
    if (bnd && s.pend >= 0) begin
      r.n = s.pend;
      r.pend = -1;
    end
    if (xf && d >= 2) begin
      if (s.act == 0 || bnd) r.n = d;
      else r.pend = d;
    end
    if (s.act == 0) begin
      r.act = en ? 1 : 0; r.stop = 0; r.cnt = 0;
    end else if (bnd) begin
      r.act = (s.stop == 0 && en) ? 1 : 0; r.stop = 0; r.cnt = 0;
    end else begin
      r.cnt = s.cnt + 1;
      if (!en) r.stop = 1;
    end
    return r;
  endfunction

  mstate_t m = model_reset();

  always @(posedge clk_in or negedge reset) begin
    if (!reset) m <= model_reset();
    else        m <= model_step(m, enable, cfg_valid, int'(cfg_div));
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk_in) begin
    check("div_out",   int'(div_out),   (m.act != 0 && m.cnt < m.n / 2) ? 1 : 0);
    check("tick",      int'(tick),      (m.act != 0 && m.cnt == m.n - 1) ? 1 : 0);
    check("busy",      int'(busy),      m.act);
    check("cfg_ready", int'(cfg_ready), (m.pend < 0) ? 1 : 0);
    check("cfg_err",   int'(cfg_err),   m.err);
    check("cur_div",   int'(cur_div),   m.n);
  end

  task automatic cyc();
    @(negedge clk_in);
  endtask

  task automatic xfer(input int d);
    cfg_valid = 1'b1;
    cfg_div   = CNT_W'(d);
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_dut_tick();
    int g = 0;
    while (tick !== 1'b1 && g < 700) begin cyc(); g++; end
    if (tick !== 1'b1) check("tick_timeout", 0, 1);
  endtask

  task automatic wait_cnt(input int v);
    int g = 0;
    while (m.cnt != v && g < 700) begin cyc(); g++; end
    if (m.cnt != v) check("cnt_timeout", m.cnt, v);
  endtask

  task automatic wait_n(input int v);
    int g = 0;
    while (m.n != v && g < 700) begin cyc(); g++; end
    if (m.n != v) check("ratio_timeout", m.n, v);
  endtask

  task automatic wait_ready();
    int g = 0;
    while (m.pend >= 0 && g < 700) begin cyc(); g++; end
    if (m.pend >= 0) check("ready_timeout", 0, 1);
  endtask

  // Measures one full period from DUT outputs alone: length and high cycles.
  task automatic measure(input string nm, input int n_exp);
    int len = 0;
    int hi  = 0;
    wait_dut_tick();
    do begin
      cyc();
      len++;
      hi += int'(div_out);
    end while (tick !== 1'b1 && len < 700);
    check({nm, "_period"}, len, n_exp);
    check({nm, "_high"}, hi, n_exp / 2);
  endtask

  initial begin
    int k;
    repeat (2) cyc();
    check("rst_div_out", int'(div_out), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cur_div", int'(cur_div), 16);
    check("rst_ready", int'(cfg_ready), 1);
    reset = 1'b1;
    cyc();

    // Start at the default ratio: first high one cycle after enable.
    enable = 1'b1;
    cyc();
    check("start_busy", int'(busy), 1);
    check("start_div_out", int'(div_out), 1);
    measure("n16", 16);

    // Ratio 6 offered mid-period: held pending until the boundary.
    wait_cnt(3);
    xfer(6);
    check("pend_ready", int'(cfg_ready), 0);
    measure("n6", 6);
    check("n6_cur_div", int'(cur_div), 6);
    check("n6_ready", int'(cfg_ready), 1);

    // Ratio 4 on the tick cycle: applies directly, never pending.
    xfer(4);
    check("n4_ready", int'(cfg_ready), 1);
    check("n4_cur_div", int'(cur_div), 4);
    measure("n4", 4);

    // Illegal ratios 1 and 0.
    cfg_valid = 1'b1; cfg_div = 8'd1; cyc(); cfg_valid = 1'b0;
    check("err1_pulse", int'(cfg_err), 1);
    check("err1_cur_div", int'(cur_div), 4);
    cyc();
    check("err1_clear", int'(cfg_err), 0);
    cfg_valid = 1'b1; cfg_div = 8'd0; cyc(); cfg_valid = 1'b0;
    check("err0_pulse", int'(cfg_err), 1);
    cyc();
    check("err0_clear", int'(cfg_err), 0);
    measure("n4b", 4);

    // Odd ratio: short high half.
    xfer(5);
    measure("n5", 5);

    // Drain at N=10: stop at cnt=5, re-request at cnt=7 is ignored.
    xfer(10);
    wait_n(10);
    wait_cnt(5);
    enable = 1'b0;
    cyc(); cyc();
    enable = 1'b1;
    k = 0;
    while (tick !== 1'b1 && k < 50) begin cyc(); k++; end
    check("drain_to_tick", k, 2);
    check("drain_busy", int'(busy), 1);
    cyc();
    check("idle_busy", int'(busy), 0);
    check("idle_div_out", int'(div_out), 0);
    cyc();
    check("rerun_busy", int'(busy), 1);
    check("rerun_div_out", int'(div_out), 1);
    measure("n10", 10);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      cfg_valid = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0)       cfg_div = CNT_W'($urandom_range(0, 1));
      else if ($urandom_range(0, 49) == 0) cfg_div = CNT_W'(255);
      else                                 cfg_div = CNT_W'($urandom_range(2, 9));
      cyc();
    end
    cfg_valid = 1'b0;

    // Maximum ratio wrap, then async reset while a ratio is pending.
    enable = 1'b1;
    wait_ready();
    xfer(255);
    wait_n(255);
    measure("n255", 255);
    wait_cnt(10);
    xfer(7);
    check("n255_pend", int'(cfg_ready), 0);
    cyc(); cyc();
    #3 reset = 1'b0;
    #1;
    check("arst_div_out", int'(div_out), 0);
    check("arst_tick", int'(tick), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_cur_div", int'(cur_div), 16);
    check("arst_ready", int'(cfg_ready), 1);
    cyc();
    reset = 1'b1;
    cyc();
    measure("post_rst", 16);
    check("post_rst_cur_div", int'(cur_div), 16);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/divider_ctrl.md
Name: divider_ctrl

Overview:
Programmable clock-divider controller and sequencer. It generates a divided square wave and a one-cycle tick from a single fast clock, and accepts divide-ratio updates over a valid/ready handshake. Ratio changes and stops only take effect on period boundaries, so the output never glitches. It sits between the config/CSR logic and the downstream consumers of the divided clock-enable (FSM timing, sampling strobes).

Parameters:
CNT_W, 8, width of the divide ratio and the period counter.
DEFAULT_DIV, 16, divide ratio loaded at reset; legal range 2..2^CNT_W-1.

Ports:
clk_in  input  1  sole clock; all logic on posedge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
enable  input  1  level request to run the divider.
cfg_valid  input  1  new ratio offered on cfg_div.
cfg_div  input  CNT_W  requested divide ratio N.
cfg_ready  output  1  controller can accept a ratio this cycle.
cfg_err  output  1  one-cycle pulse: accepted handshake carried an illegal ratio (N<2).
div_out  output  1  divided square wave, registered.
tick  output  1  one-cycle pulse in the last cycle of each period, registered.
cur_div  output  CNT_W  ratio currently in effect.
busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE, cnt=0, cur_div=DEFAULT_DIV, pend_vld=0, div_out=0, tick=0, cfg_err=0. cfg_ready=1 immediately.
- Period counter: cnt runs 0..cur_div-1, then wraps to 0.
- div_out=1 when cnt < (cur_div>>1), otherwise 0. Odd N gives a short-high wave (e.g. N=5: 2 high, 3 low).
- tick=1 exactly when cnt==cur_div-1.
- Outputs are registered and change in the same cycle as cnt.
- Handshake: a transfer occurs when cfg_valid && cfg_ready. cfg_ready = !pend_vld.
- Illegal N (0 or 1): consumed, cfg_err pulses the next cycle, no other state changes.
- States are IDLE, RUN, PEND, DRAIN.
- IDLE:
  - cnt=0, div_out=0, tick=0.
  - A legal transfer loads cur_div directly on the next cycle.
  - enable=1 -> RUN next cycle, with cnt=0 and div_out=1.
- RUN:
  - A legal transfer stores the value in pend_reg, sets pend_vld -> PEND.
  - Exception: a transfer on the tick cycle is loaded into cur_div directly, and the new period starts with the new N next cycle.
  - enable=0 -> DRAIN.
- PEND:
  - Counting continues with the old N.
  - On the tick cycle: cur_div<=pend_reg, pend_vld<=0, cnt<=0 -> RUN.
  - enable=0 -> DRAIN, keeping pend_vld.
- DRAIN:
  - Counting continues until the tick cycle, then IDLE.
  - If pend_vld, cur_div<=pend_reg and pend_vld<=0 at that boundary.
  - enable re-asserted during DRAIN is ignored until IDLE. IDLE then goes to RUN on the following cycle if enable is still high.
- enable=0 on the tick cycle in RUN: goes straight to IDLE; the period is already complete.
- Latency: enable rise to first div_out=1 is 1 cycle. A ratio change takes effect at most cur_div cycles after the handshake.
- Width rule: cnt is compared against cur_div-1 computed in CNT_W bits; N=2^CNT_W-1 must wrap correctly.
- Reset mid-period aborts immediately: outputs drop to 0 and the pending ratio is discarded.

Decomposition:
- Package divider_ctrl_pkg holds:
  - state_t enum {IDLE, RUN, PEND, DRAIN};
  - constant DIV_MIN=2;
  - a function that checks whether a ratio is legal.
- One sub-module, div_period_cnt: owns cnt, div_out and tick. Its inputs are cur_div, run and restart.
- divider_ctrl keeps the FSM, the pending register and the handshake.

Test Plan:
- Reset, enable=1, default N=16 -> div_out 8 high/8 low; tick every 16 cycles, in the cycle where cnt=15; busy=1.
- While running at N=16, transfer cfg_div=6 at cnt=3 -> cfg_ready=0 until the cycle after the next tick; that period still lasts 16 cycles, then periods are 6 (3 high/3 low) and cur_div=6.
- Transfer cfg_div=4 exactly on the tick cycle -> next period is 4 cycles, no PEND, cfg_ready stays 1.
- cfg_div=1 with valid in RUN -> cfg_err one-cycle pulse, cur_div unchanged, waveform undisturbed; repeat with cfg_div=0.
- enable dropped at cnt=5 with N=10 -> DRAIN, the period completes (tick at cnt=9), then IDLE with div_out=0; re-raising enable mid-drain starts RUN only after IDLE.
- reset asserted asynchronously mid-PEND with N=255 -> all outputs 0 immediately, cur_div=16 after release, pending ratio lost; N=255 wrap is checked beforehand.
